// File: rtl/qed_instr_cache.sv
// Instruction record/replay cache: records the original fetch stream, then
// replays it once for the duplicate stream. Output is registered, one ena-cycle late.
module qed_instr_cache #(
  parameter int          DEPTH = 16,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     exec_dup,
  input  logic                     ifu_vld,
  input  logic [31:0]              ifu_instruction,
  output logic [31:0]              qic_qimux_instruction,
  output logic                     qic_vld,
  output logic                     cache_full,
  output logic                     replay_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  localparam logic [1:0] S_RECORD = 2'd0;
  localparam logic [1:0] S_REPLAY = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_out;
  logic          r_vld;
  logic          r_full;
  logic          r_done;
  logic [31:0]   r_mem [DEPTH];

  logic [1:0]    w_mode;
  logic [CW-1:0] w_base_cnt;
  logic [PW-1:0] w_base_wr;
  logic [PW-1:0] w_rd_idx;
  logic          w_rec;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_rd_nxt;

  assign qic_qimux_instruction = r_out;
  assign qic_vld               = r_vld;
  assign cache_full            = r_full;
  assign replay_done           = r_done;
  assign count                 = r_count;

  // The mode this cycle is handled in: a mode change takes effect on the same cycle it is seen.
  always_comb begin
    w_mode     = r_state;
    w_base_cnt = r_count;
    w_base_wr  = r_wr_ptr;
    w_rd_idx   = r_rd_ptr;
    case (r_state)
      S_RECORD: begin
        if (exec_dup) begin
          w_mode   = (r_count != {CW{1'b0}}) ? S_REPLAY : S_DONE;
          w_rd_idx = {PW{1'b0}};
        end else begin
          w_mode = S_RECORD;
        end
      end
      S_REPLAY, S_DONE: begin
        if (!exec_dup) begin
          w_mode     = S_RECORD;
          w_base_cnt = {CW{1'b0}};
          w_base_wr  = {PW{1'b0}};
        end else begin
          w_mode = r_state;
        end
      end
      default: begin
        w_mode     = S_RECORD;
        w_base_cnt = {CW{1'b0}};
        w_base_wr  = {PW{1'b0}};
      end
    endcase
    w_rec     = (w_mode == S_RECORD) && ifu_vld && (ifu_instruction != NOP) &&
                (w_base_cnt < L_DEPTH);
    w_cnt_nxt = w_rec ? (w_base_cnt + {{(CW-1){1'b0}}, 1'b1}) : w_base_cnt;
    w_rd_nxt  = {1'b0, w_rd_idx} + {{(CW-1){1'b0}}, 1'b1};
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RECORD;
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_out    <= NOP;
      r_vld    <= 1'b0;
      r_full   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ena) begin
      case (w_mode)
        S_RECORD: begin
          r_state  <= S_RECORD;
          r_wr_ptr <= w_rec ? (w_base_wr + {{(PW-1){1'b0}}, 1'b1}) : w_base_wr;
          r_rd_ptr <= {PW{1'b0}};
          r_count  <= w_cnt_nxt;
          r_out    <= ifu_instruction;
          r_vld    <= ifu_vld;
          r_full   <= (w_cnt_nxt == L_DEPTH);
          r_done   <= 1'b0;
        end
        S_REPLAY: begin
          r_out    <= r_mem[w_rd_idx];
          r_vld    <= 1'b1;
          r_done   <= 1'b0;
          r_rd_ptr <= w_rd_nxt[PW-1:0];
          r_state  <= (w_rd_nxt == r_count) ? S_DONE : S_REPLAY;
        end
        S_DONE: begin
          r_state <= S_DONE;
          r_out   <= NOP;
          r_vld   <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_RECORD;
        end
      endcase
    end
  end

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && ena && w_rec) begin
      r_mem[w_base_wr] <= ifu_instruction;
    end
  end

endmodule

// File: tb/tb_qed_instr_cache.sv
// Directed bench for qed_instr_cache: expectations are pushed to a scoreboard
// when stimulus is driven and popped when the registered output appears.
module tb_qed_instr_cache;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        done;
    logic        full;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        exec_dup = 1'b0;
  logic        ifu_vld = 1'b0;
  logic [31:0] ifu_instruction = 32'h0;
  logic [31:0] qic_qimux_instruction;
  logic        qic_vld;
  logic        cache_full;
  logic        replay_done;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb_q[$];
  exp_t        last;
  logic [31:0] rec_q[$];
  int          m_rd  = 0;
  bit          m_rep = 1'b0;

  qed_instr_cache #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ena                   (ena),
    .exec_dup              (exec_dup),
    .ifu_vld               (ifu_vld),
    .ifu_instruction       (ifu_instruction),
    .qic_qimux_instruction (qic_qimux_instruction),
    .qic_vld               (qic_vld),
    .cache_full            (cache_full),
    .replay_done           (replay_done),
    .count                 (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input string pfx);
    check({pfx, ".instr"}, qic_qimux_instruction, e.instr);
    check({pfx, ".vld"},   {31'd0, qic_vld},      {31'd0, e.vld});
    check({pfx, ".done"},  {31'd0, replay_done},  {31'd0, e.done});
    check({pfx, ".full"},  {31'd0, cache_full},   {31'd0, e.full});
    check({pfx, ".count"}, {28'd0, count},        {28'd0, e.cnt});
  endtask

  // One clock of stimulus; the bench's own record/replay model produces the expectation.
  task automatic step(input string pfx, input logic en, input logic dup,
                      input logic v, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    ena = en; exec_dup = dup; ifu_vld = v; ifu_instruction = ins;
    if (en) begin
      if (!dup) begin
        if (m_rep) begin
          rec_q.delete();
          m_rd  = 0;
          m_rep = 1'b0;
        end
        e.instr = ins; e.vld = v; e.done = 1'b0;
        if (v && ins != NOP && rec_q.size() < DEPTH) rec_q.push_back(ins);
      end else begin
        m_rep = 1'b1;
        if (m_rd < rec_q.size()) begin
          e.instr = rec_q[m_rd]; e.vld = 1'b1; e.done = 1'b0;
          m_rd++;
        end else begin
          e.instr = NOP; e.vld = 1'b0; e.done = 1'b1;
        end
      end
      e.full = (rec_q.size() == DEPTH);
      e.cnt  = 4'(rec_q.size());
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      if (sb_q.size() == 0) check({pfx, ".sb_empty"}, 32'd0, 32'd1);
      else begin
        e = sb_q.pop_front();
        cmp(e, pfx);
        last = e;
      end
    end else begin
      cmp(last, {pfx, ".hold"});
    end
  endtask

  task automatic do_rst(input logic en);
    @(negedge clk);
    rst = 1'b1; ena = en; exec_dup = 1'b1; ifu_vld = 1'b1; ifu_instruction = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_q.delete(); m_rd = 0; m_rep = 1'b0; sb_q.delete();
    last = '{instr: NOP, vld: 1'b0, done: 1'b0, full: 1'b0, cnt: 4'd0};
    cmp(last, "reset");
  endtask

  initial begin
    // Reset, once with ena high and once with ena low
    do_rst(1'b1);
    do_rst(1'b0);

    // Basic record of three instructions, then replay and DONE
    step("r031", 1'b1, 1'b0, 1'b1, 32'h00500093);
    step("r031", 1'b1, 1'b0, 1'b1, 32'h00A00113);
    step("r031", 1'b1, 1'b0, 1'b1, 32'h002081B3);
    for (int i = 0; i < 5; i++) step("p031", 1'b1, 1'b1, 1'b1, 32'h11111111);

    // Interleaved NOP and invalid cycles are passed but not recorded
    step("r032", 1'b1, 1'b0, 1'b1, 32'hAAAA0001);
    step("r032", 1'b1, 1'b0, 1'b1, NOP);
    step("r032", 1'b1, 1'b0, 1'b0, 32'hBBBB0002);
    step("r032", 1'b1, 1'b0, 1'b1, 32'hCCCC0003);
    step("r032", 1'b1, 1'b0, 1'b0, NOP);
    step("r032", 1'b1, 1'b0, 1'b1, 32'hDDDD0004);
    for (int i = 0; i < 5; i++) step("p032", 1'b1, 1'b1, 1'b0, 32'h0);

    // Overfill: DEPTH+2 distinct words, only DEPTH kept
    for (int i = 0; i < DEPTH + 2; i++)
      step("r033", 1'b1, 1'b0, 1'b1, 32'h10000000 + 32'(i));
    for (int i = 0; i < DEPTH + 2; i++) step("p033", 1'b1, 1'b1, 1'b1, 32'h0);

    // Random stalls during record and replay
    for (int i = 0; i < 12; i++)
      step("r034", 1'($urandom_range(0, 1)), 1'b0, 1'b1, 32'h20000000 + 32'(i));
    for (int i = 0; i < 20; i++)
      step("p034", 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), $urandom);

    // Abort replay after two of five entries
    for (int i = 0; i < 5; i++) step("r035", 1'b1, 1'b0, 1'b1, 32'h30000000 + 32'(i));
    step("p035", 1'b1, 1'b1, 1'b0, 32'h0);
    step("p035", 1'b1, 1'b1, 1'b0, 32'h0);
    step("a035", 1'b1, 1'b0, 1'b1, 32'h3000ABCD);
    step("a035", 1'b1, 1'b1, 1'b0, 32'h0);
    step("a035", 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset while stalled mid-replay discards the recording
    step("r036", 1'b1, 1'b0, 1'b1, 32'h40000001);
    step("r036", 1'b1, 1'b0, 1'b1, 32'h40000002);
    step("r036", 1'b1, 1'b0, 1'b1, 32'h40000003);
    step("p036", 1'b1, 1'b1, 1'b0, 32'h0);
    do_rst(1'b0);
    step("q036", 1'b1, 1'b1, 1'b0, 32'h0);
    step("q036", 1'b1, 1'b0, 1'b1, 32'h40000004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qed_instr_cache.md
QED_INSTR_CACHE -- requirements
Module: qed_instr_cache

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of 32-bit instruction entries (power of two, 2..64).
REQ-002 Parameter NOP, default 32'h00000013, meaning the canonical no-op word (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ena  input  1  pipeline advance; 0 = stall, all state and outputs held.
REQ-006 exec_dup  input  1  mode select; 0 = record/original stream, 1 = replay/duplicate stream.
REQ-007 ifu_vld  input  1  fetched instruction valid.
REQ-008 ifu_instruction  input  32  fetched instruction word.
REQ-009 qic_qimux_instruction  output  32  registered instruction to the modify/mux stage.
REQ-010 qic_vld  output  1  qic_qimux_instruction carries a real instruction.
REQ-011 cache_full  output  1  recorded count equals DEPTH.
REQ-012 replay_done  output  1  all recorded entries have been replayed.
REQ-013 count  output  $clog2(DEPTH)+1  number of recorded entries.

Function
REQ-014 The block SHALL be a three-state FSM: RECORD, REPLAY, DONE; encoding is free.
REQ-015 All outputs SHALL be registered; latency from input sample to output SHALL be exactly 1 ena-qualified cycle.
REQ-016 With ena=0 the block SHALL hold state, pointers, memory and all outputs unchanged, regardless of other inputs.
REQ-017 RECORD, ena=1: output SHALL be ifu_instruction with qic_vld=ifu_vld (pass-through, one-cycle registered).
REQ-018 RECORD, ena=1, ifu_vld=1, ifu_instruction!=NOP, count<DEPTH: word SHALL be written at wr_ptr and wr_ptr/count incremented by 1.
REQ-019 NOP words and ifu_vld=0 cycles SHALL NOT be recorded but SHALL still pass through.
REQ-020 When count==DEPTH, cache_full SHALL be 1; further instructions SHALL pass through unrecorded; no wrap-around or overwrite.
REQ-021 RECORD->REPLAY on ena=1 with exec_dup=1 and count>0; rd_ptr SHALL start at 0; fetch inputs SHALL be ignored until RECORD.
REQ-022 RECORD->DONE directly on ena=1 with exec_dup=1 and count==0.
REQ-023 REPLAY, ena=1: output SHALL be mem[rd_ptr], qic_vld=1, rd_ptr incremented; after the entry at count-1 is emitted, next state SHALL be DONE.
REQ-024 Replay order SHALL equal record order; each recorded entry SHALL be emitted exactly once.
REQ-025 DONE: output SHALL be NOP, qic_vld=0, replay_done=1; state held while exec_dup=1.
REQ-026 REPLAY or DONE, ena=1, exec_dup=0: next state RECORD; wr_ptr, rd_ptr, count cleared; cache_full and replay_done cleared; same-cycle input SHALL be handled as RECORD (pass-through, recorded if eligible).
REQ-027 exec_dup falling mid-REPLAY SHALL abort the replay with the REQ-026 behaviour; unreplayed entries are discarded.
REQ-028 Pointer widths SHALL be $clog2(DEPTH); count SHALL reach DEPTH without overflow.

Reset
REQ-029 With rst=1 at a clock edge, regardless of ena: state RECORD, wr_ptr=rd_ptr=count=0, qic_qimux_instruction=NOP, qic_vld=0, cache_full=0, replay_done=0.
REQ-030 Memory contents SHALL NOT require reset; rst mid-REPLAY SHALL discard all recorded entries.

Verification
REQ-031 Record 3 instrs (0x00500093, 0x00A00113, 0x002081B3), exec_dup=1 -> replay of the same 3 words in order, qic_vld=1, then NOP with replay_done=1 and qic_vld=0.
REQ-032 Record with interleaved NOP and ifu_vld=0 cycles -> count excludes them; pass-through outputs match inputs delayed 1 cycle.
REQ-033 Record DEPTH+2 distinct instrs -> cache_full=1 at count=DEPTH; replay emits the first DEPTH only.
REQ-034 ena toggled 0/1 randomly during record and replay -> output sequence identical to ena=1 run, no duplicates or drops.
REQ-035 exec_dup 1 after 2 of 5 replayed, then 0 -> RECORD, count=0, next fetched instr passes through and is recorded at entry 0.
REQ-036 rst asserted mid-REPLAY with ena=0 -> next cycle outputs NOP, qic_vld=0, count=0, state RECORD.
